lutram_readback_checker: RTL and testbench

- Downstream consumer of the distributed-RAM primitive test stage. Samples the SPO/DPO outputs while the stage walks its CLEAR, WRITE and READ phases.
- Checks every address against the expected pattern: pre-write value 0 during WRITE, written pattern during READ.
- Reports pass/fail, a saturating error count, the first failing address and port, and address/phase sequence violations.
- Runs on the fast BUFG clock. The stage's slow-clock activity is presented as a one-cycle sample strobe.

---
 rtl/lutram_readback_checker_if.sv | 22 ++
 rtl/lutram_readback_checker.sv | 194 +++++++++++++++++++
 tb/tb_lutram_readback_checker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lutram_readback_checker_if.sv
//------------------------------------------------------------------------------
// Module  : lutram_readback_checker_if
// Brief   : Sample bus from the LUTRAM test stage to its readback checker.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface lutram_readback_checker_if #(
    parameter int A_WIDTH = 6
) ();
    logic               sample_en;
    logic [1:0]         phase;
    logic [A_WIDTH-1:0] addr;
    logic               spo;
    logic               dpo;

    modport master (output sample_en, phase, addr, spo, dpo);
    modport slave  (input  sample_en, phase, addr, spo, dpo);
endinterface

`default_nettype wire

// File: rtl/lutram_readback_checker.sv
//------------------------------------------------------------------------------
// Module  : lutram_readback_checker
// Brief   : Checks SPO/DPO readback of a distributed-RAM test stage across its
//           WRITE and READ walks. Optional macro DPO_CHECK_EN enables DPO checking.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lutram_readback_checker #(
    parameter int A_WIDTH   = 6,
    parameter int CNT_WIDTH = 8,
    parameter int PATTERN   = 0
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_n_i,
    input  wire logic                 start_i,
    lutram_readback_checker_if.slave  smp,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [CNT_WIDTH-1:0]      err_cnt_o,
    output logic [A_WIDTH-1:0]        first_err_addr_o,
    output logic [1:0]                first_err_port_o,
    output logic                      seq_err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_WR = 3'd1,
        S_CHK_WR  = 3'd2,
        S_CHK_RD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0]           c_ph_write  = 2'b10;
    localparam logic [1:0]           c_ph_read   = 2'b11;
    localparam logic [A_WIDTH-1:0]   c_addr_zero = '0;
    localparam logic [A_WIDTH-1:0]   c_addr_last = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = '1;

    state_t                 r_state;
    logic [A_WIDTH-1:0]     r_exp_addr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [CNT_WIDTH-1:0]   r_err_cnt;
    logic [A_WIDTH-1:0]     r_first_addr;
    logic [1:0]             r_first_port;
    logic                   r_seq_err;

    logic [A_WIDTH-1:0]     w_addr;
    logic [1:0]             w_phase;
    logic                   w_pat_bit;
    logic                   w_exp_data;
    logic                   w_spo_bad;
    logic                   w_dpo_bad;
    logic                   w_mismatch;
    logic                   w_in_order;
    logic                   w_last;
    logic [CNT_WIDTH-1:0]   w_err_cnt_nxt;
    logic                   w_first_latch;

    assign w_addr  = smp.addr;
    assign w_phase = smp.phase;

    assign w_pat_bit  = (PATTERN != 0) ? ~w_addr[0] : w_addr[0];
    // RAM content is all zero after CLEAR, so only READ compares against the pattern.
    assign w_exp_data = (r_state == S_CHK_RD) ? w_pat_bit : 1'b0;
    assign w_spo_bad  = (smp.spo != w_exp_data);

`ifdef DPO_CHECK_EN
    assign w_dpo_bad  = (smp.dpo != w_exp_data);
`else
    logic w_unused_dpo;
    assign w_unused_dpo = smp.dpo;
    assign w_dpo_bad    = 1'b0;
`endif

    assign w_mismatch = w_spo_bad | w_dpo_bad;
    assign w_last     = (w_addr == c_addr_last);

    always_comb begin
        w_in_order = 1'b0;
        if (w_addr == r_exp_addr) begin
            if (r_state == S_CHK_WR)
                w_in_order = (w_phase == c_ph_write);
            else if (r_state == S_CHK_RD)
                w_in_order = (w_phase == c_ph_read);
        end
    end

    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (w_mismatch && (r_err_cnt != c_cnt_max))
            w_err_cnt_nxt = r_err_cnt + 1'b1;
    end

    // A zero count means no mismatch has been seen since start.
    assign w_first_latch = w_mismatch && (r_err_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_exp_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_port <= 2'b00;
            r_seq_err    <= 1'b0;
        end else if (start_i) begin
            r_state      <= S_WAIT_WR;
            r_exp_addr   <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_port <= 2'b00;
            r_seq_err    <= 1'b0;
        end else if (smp.sample_en) begin
            case (r_state)
                S_WAIT_WR: begin
                    if (w_phase == c_ph_write) begin
                        if (w_addr == c_addr_zero) begin
                            r_err_cnt <= w_err_cnt_nxt;
                            if (w_first_latch) begin
                                r_first_addr <= w_addr;
                                r_first_port <= {w_dpo_bad, w_spo_bad};
                            end
                            r_exp_addr <= c_addr_zero + 1'b1;
                            r_state    <= S_CHK_WR;
                        end else begin
                            r_seq_err <= 1'b1;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end else if (w_phase == c_ph_read) begin
                        // READ before any WRITE is an ordering fault.
                        r_seq_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_CHK_WR, S_CHK_RD: begin
                    if (w_in_order) begin
                        r_err_cnt <= w_err_cnt_nxt;
                        if (w_first_latch) begin
                            r_first_addr <= w_addr;
                            r_first_port <= {w_dpo_bad, w_spo_bad};
                        end
                        if (!w_last) begin
                            r_exp_addr <= r_exp_addr + 1'b1;
                        end else if (r_state == S_CHK_WR) begin
                            r_exp_addr <= '0;
                            r_state    <= S_CHK_RD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_cnt_nxt == '0);
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_seq_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end

                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_addr;
    assign first_err_port_o = r_first_port;
    assign seq_err_o        = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_lutram_readback_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_lutram_readback_checker
// Brief   : Directed bench with done-triggered scoreboard for the readback checker.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lutram_readback_checker;

    localparam int A_WIDTH   = 6;
    localparam int CNT_WIDTH = 4;
    localparam int DEPTH     = 1 << A_WIDTH;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 busy_o;
    logic                 done_o;
    logic                 pass_o;
    logic [CNT_WIDTH-1:0] err_cnt_o;
    logic [A_WIDTH-1:0]   first_err_addr_o;
    logic [1:0]           first_err_port_o;
    logic                 seq_err_o;

    lutram_readback_checker_if #(.A_WIDTH(A_WIDTH)) smp ();

    lutram_readback_checker #(
        .A_WIDTH   (A_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .PATTERN   (0)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .smp              (smp),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o),
        .first_err_port_o (first_err_port_o),
        .seq_err_o        (seq_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int faddr;
        int fport;
        int seq;
        int pass;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_q = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: each rising done_o is the DUT's result for one queued run.
    always @(negedge clk) begin
        if (rst_n && done_o && !done_q) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("err_cnt",    int'(err_cnt_o),        e.cnt);
                check("first_addr", int'(first_err_addr_o), e.faddr);
                check("first_port", int'(first_err_port_o), e.fport);
                check("seq_err",    int'(seq_err_o),        e.seq);
                check("pass",       int'(pass_o),           e.pass);
            end
        end
        done_q <= done_o;
    end

    task automatic push_exp(input int c, input int a, input int p, input int s, input int ps);
        exp_t e;
        e.cnt = c; e.faddr = a; e.fport = p; e.seq = s; e.pass = ps;
        q.push_back(e);
    endtask

    task automatic strobe(input logic [1:0] ph, input int a, input logic s, input logic d);
        @(posedge clk); #1;
        smp.sample_en = 1'b1;
        smp.phase     = ph;
        smp.addr      = A_WIDTH'(a);
        smp.spo       = s;
        smp.dpo       = d;
        @(posedge clk); #1;
        smp.sample_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic clear_phase(input logic dforce);
        for (int a = 0; a < DEPTH; a++) strobe(2'b01, a, 1'b0, dforce);
    endtask

    task automatic write_phase(input logic dforce);
        for (int a = 0; a < DEPTH; a++) strobe(2'b10, a, 1'b0, dforce);
    endtask

    // Reads addresses 0..n-1; spo is inverted for addresses in [e0, e0+en).
    task automatic read_phase(input int e0, input int en, input logic dforce, input int n);
        for (int a = 0; a < n; a++) begin
            logic b;
            b = (a % 2) != 0;
            strobe(2'b11, a, b ^ ((a >= e0) && (a < e0 + en)), dforce ? 1'b1 : b);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got pending=%0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        smp.sample_en = 1'b0;
        smp.phase     = 2'b00;
        smp.addr      = '0;
        smp.spo       = 1'b0;
        smp.dpo       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_busy",    int'(busy_o),    0);
        check("rst_done",    int'(done_o),    0);
        check("rst_pass",    int'(pass_o),    0);
        check("rst_err_cnt", int'(err_cnt_o), 0);
        check("rst_seq_err", int'(seq_err_o), 0);

        // Samples in IDLE are ignored.
        strobe(2'b10, 0, 1'b1, 1'b1);
        check("idle_busy", int'(busy_o), 0);

        // Clean run.
        pulse_start();
        check("start_busy", int'(busy_o), 1);
        push_exp(0, 0, 0, 0, 1);
        clear_phase(1'b0); write_phase(1'b0); read_phase(0, 0, 1'b0, DEPTH);
        wait_drain();

        // Stuck bit at READ address 5.
        pulse_start();
        push_exp(1, 5, 1, 0, 0);
        clear_phase(1'b0); write_phase(1'b0); read_phase(5, 1, 1'b0, DEPTH);
        wait_drain();

        // Saturation: 20 read mismatches from address 20.
        pulse_start();
        push_exp(15, 20, 1, 0, 0);
        clear_phase(1'b0); write_phase(1'b0); read_phase(20, 20, 1'b0, DEPTH);
        wait_drain();

        // Sequence fault: address 10 followed by 12 during WRITE.
        pulse_start();
        push_exp(0, 0, 0, 1, 0);
        clear_phase(1'b0);
        for (int a = 0; a <= 10; a++) strobe(2'b10, a, 1'b0, 1'b0);
        check("seq_done_before", int'(done_o), 0);
        strobe(2'b10, 12, 1'b0, 1'b0);
        check("seq_done_after", int'(done_o),    1);
        check("seq_err_after",  int'(seq_err_o), 1);
        wait_drain();

        // Restart mid-READ with three errors accumulated.
        pulse_start();
        clear_phase(1'b0); write_phase(1'b0); read_phase(1, 3, 1'b0, 10);
        check("mid_err_cnt", int'(err_cnt_o), 3);
        pulse_start();
        check("restart_err_cnt", int'(err_cnt_o), 0);
        check("restart_busy",    int'(busy_o),    1);
        check("restart_done",    int'(done_o),    0);
        push_exp(0, 0, 0, 0, 1);
        clear_phase(1'b0); write_phase(1'b0); read_phase(0, 0, 1'b0, DEPTH);
        wait_drain();

        // DPO forced high for a whole run.
        pulse_start();
`ifdef DPO_CHECK_EN
        push_exp(15, 0, 2, 0, 0);
`else
        push_exp(0, 0, 0, 0, 1);
`endif
        clear_phase(1'b1); write_phase(1'b1); read_phase(0, 0, 1'b1, DEPTH);
        wait_drain();

        // Reset mid-operation returns to IDLE with statistics cleared.
        pulse_start();
        write_phase(1'b0); read_phase(2, 2, 1'b0, 6);
        @(negedge clk); rst_n = 1'b0;
        #2;
        check("arst_busy",    int'(busy_o),    0);
        check("arst_err_cnt", int'(err_cnt_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
